// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receiver: FSM state encoding and
// the width of the dropped-frame counter.
package i2s_pkg;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } i2s_rx_state_t;

   localparam int I2S_OVERRUN_CNT_W = 16;

endpackage

// File: rtl/i2s_rx_if.sv
// Stereo frame stream from i2s_rx to its consumer: left/right words with a
// single valid/ready pair covering both.
interface i2s_rx_if #(
   parameter int WIDTH = 24
);

   logic [WIDTH-1:0] output_l_tdata;
   logic [WIDTH-1:0] output_r_tdata;
   logic             output_tvalid;
   logic             output_tready;

   modport master (
      output output_l_tdata,
      output output_r_tdata,
      output output_tvalid,
      input  output_tready
   );

   modport slave (
      input  output_l_tdata,
      input  output_r_tdata,
      input  output_tvalid,
      output output_tready
   );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer bringing an asynchronous input into the
// clk_in domain.
module sync_2ff (
   input  logic clk_in,
   input  logic rst_in,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sck/ws/sd, deserializes left/right words and
// presents stereo frames on a valid/ready stream.
// Define I2S_RX_OVERRUN_CNT_EN to build the saturating dropped-frame counter.
//
// state | meaning
// SYNC  | not aligned; wait for the first ws 1->0 transition
// LEFT  | capturing the left word
// RIGHT | capturing the right word; ws 1->0 completes a frame
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         sck,
   input  logic                         ws,
   input  logic                         sd,
   i2s_rx_if.master                     m_axis,
   output logic                         locked,
   output logic [I2S_OVERRUN_CNT_W-1:0] overrun_count
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   typedef logic [CNT_W-1:0] cnt_t;
   localparam cnt_t             CNT_MAX = cnt_t'(WIDTH);
   localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH - 1){1'b0}}};

   logic sck_s, ws_s, sd_s;

   sync_2ff u_sync_sck (.clk_in(clk_in), .rst_in(rst_in), .d(sck), .q(sck_s));
   sync_2ff u_sync_ws  (.clk_in(clk_in), .rst_in(rst_in), .d(ws),  .q(ws_s));
   sync_2ff u_sync_sd  (.clk_in(clk_in), .rst_in(rst_in), .d(sd),  .q(sd_s));

   logic             sck_prev_q, sck_prev_d;
   logic             sck_rise_q, sck_rise_d;
   logic             ws_smp_q, ws_smp_d;
   logic             sd_smp_q, sd_smp_d;
   logic             ws_prev_q, ws_prev_d;
   cnt_t             bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] left_hold_q, left_hold_d;
   logic [WIDTH-1:0] out_l_q, out_l_d;
   logic [WIDTH-1:0] out_r_q, out_r_d;
   logic             tvalid_q, tvalid_d;
   i2s_rx_state_t    state_q, state_d;

   logic             word_end;
   logic             frame_done;
   logic             accept;
   logic             load;
   logic [WIDTH-1:0] shift_ins;

   // Edge and samples are registered once more so protocol work runs one
   // cycle after the synchronized rise is seen.
   always_comb begin
      sck_prev_d  = sck_s;
      sck_rise_d  = sck_s & ~sck_prev_q;
      ws_smp_d    = ws_s;
      sd_smp_d    = sd_s;
      ws_prev_d   = ws_prev_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      left_hold_d = left_hold_q;
      state_d     = state_q;
      frame_done  = 1'b0;
      word_end    = (ws_smp_q != ws_prev_q);
      shift_ins   = shift_q;

      // Each position is written at most once per word, so OR-ing is exact.
      if ((bit_cnt_q < CNT_MAX) && sd_smp_q) begin
         shift_ins = shift_q | (MSB_ONE >> bit_cnt_q);
      end

      if (sck_rise_q) begin
         ws_prev_d = ws_smp_q;
         if (word_end) begin
            bit_cnt_d = '0;
            shift_d   = '0;
         end else begin
            shift_d = shift_ins;
            if (bit_cnt_q < CNT_MAX) begin
               bit_cnt_d = bit_cnt_q + cnt_t'(1);
            end
         end

         case (state_q)
            SYNC: begin
               if (word_end && !ws_smp_q) state_d = LEFT;
            end
            LEFT: begin
               if (word_end && ws_smp_q) begin
                  left_hold_d = shift_ins;
                  state_d     = RIGHT;
               end
            end
            RIGHT: begin
               if (word_end && !ws_smp_q) begin
                  frame_done = 1'b1;
                  state_d    = LEFT;
               end
            end
            default: state_d = SYNC;
         endcase
      end
   end

   always_comb begin
      accept   = tvalid_q & m_axis.output_tready;
      load     = frame_done & (~tvalid_q | accept);
      out_l_d  = load ? left_hold_q : out_l_q;
      out_r_d  = load ? shift_ins : out_r_q;
      tvalid_d = load | (tvalid_q & ~accept);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sck_prev_q  <= 1'b0;
         sck_rise_q  <= 1'b0;
         ws_smp_q    <= 1'b0;
         sd_smp_q    <= 1'b0;
         ws_prev_q   <= 1'b0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         left_hold_q <= '0;
         out_l_q     <= '0;
         out_r_q     <= '0;
         tvalid_q    <= 1'b0;
         state_q     <= SYNC;
      end else begin
         sck_prev_q  <= sck_prev_d;
         sck_rise_q  <= sck_rise_d;
         ws_smp_q    <= ws_smp_d;
         sd_smp_q    <= sd_smp_d;
         ws_prev_q   <= ws_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         left_hold_q <= left_hold_d;
         out_l_q     <= out_l_d;
         out_r_q     <= out_r_d;
         tvalid_q    <= tvalid_d;
         state_q     <= state_d;
      end
   end

`ifdef I2S_RX_OVERRUN_CNT_EN
   logic [I2S_OVERRUN_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;

   always_comb begin
      ovr_cnt_d = ovr_cnt_q;
      if (frame_done && !load && (ovr_cnt_q != '1)) begin
         ovr_cnt_d = ovr_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         ovr_cnt_q <= '0;
      end else begin
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign overrun_count = ovr_cnt_q;
`else
   assign overrun_count = '0;
`endif

   assign m_axis.output_l_tdata = out_l_q;
   assign m_axis.output_r_tdata = out_r_q;
   assign m_axis.output_tvalid  = tvalid_q;
   assign locked                = (state_q != SYNC);

endmodule
